// File: rtl/pong_pmod_pkg.sv
// Shared definitions for the pong PMOD I/O path: FSM state encoding and PMOD pin indices.
package pong_pmod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_LATCH    = 2'd3
  } state_t;

  localparam int PIN_SER   = 0;
  localparam int PIN_SRCLK = 1;
  localparam int PIN_RCLK  = 2;

endpackage

// File: rtl/pmod_tick_gen.sv
// Phase divider for the 74HC595 driver: counts 0..CLK_DIV-1 and flags the last cycle of each phase.
module pmod_tick_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/pmod_shift_tx.sv
// Serial transmitter for a 74HC595 on the output PMOD (SER/SRCLK/RCLK).
// Optional macro PMOD_SHIFT_TX_SKIP_DUP_EN: frames equal to the last latched value are dropped.
module pmod_shift_tx
  import pong_pmod_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 50,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic [2:0]        pmod_out
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [BIT_W-1:0]  r_bit;
  logic [2:0]        r_pmod;
  logic              r_ready;

  logic              w_tick;
  logic              w_accept;
  logic              w_dup;
  logic              w_start;
  logic              w_first_bit;
  logic [DATA_W-1:0] w_shift_next;
  logic              w_next_bit;

  assign w_accept     = tx_valid && r_ready;
  assign w_start      = w_accept && !w_dup;
  assign w_first_bit  = (MSB_FIRST != 0) ? tx_data[DATA_W-1] : tx_data[0];
  assign w_shift_next = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
  assign w_next_bit   = (MSB_FIRST != 0) ? w_shift_next[DATA_W-1] : w_shift_next[0];

  // Divider restarts on accept so the first SHIFT_LO phase is a full CLK_DIV cycles.
  pmod_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (w_start),
    .tick  (w_tick)
  );

`ifdef PMOD_SHIFT_TX_SKIP_DUP_EN
  logic [DATA_W-1:0] r_frame;
  logic [DATA_W-1:0] r_last_sent;

  assign w_dup = (tx_data == r_last_sent);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame     <= '0;
      r_last_sent <= '0;
    end else begin
      if (r_state == ST_IDLE && w_start) r_frame <= tx_data;
      if (r_state == ST_LATCH && w_tick) r_last_sent <= r_frame;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  // NOTE: non-blocking assignments only, so every pin and counter updates from the same pre-edge state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_pmod  <= 3'b000;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pmod <= 3'b000;
          if (w_start) begin
            r_state         <= ST_SHIFT_LO;
            r_ready         <= 1'b0;
            r_shift         <= tx_data;
            r_bit           <= '0;
            r_pmod[PIN_SER] <= w_first_bit;
          end
        end
        ST_SHIFT_LO: begin
          if (w_tick) begin
            r_state           <= ST_SHIFT_HI;
            r_pmod[PIN_SRCLK] <= 1'b1;
          end
        end
        ST_SHIFT_HI: begin
          if (w_tick) begin
            r_pmod[PIN_SRCLK] <= 1'b0;
            if (r_bit == LAST_BIT) begin
              r_state          <= ST_LATCH;
              r_pmod[PIN_RCLK] <= 1'b1;
            end else begin
              r_state         <= ST_SHIFT_LO;
              r_bit           <= r_bit + 1'b1;
              r_shift         <= w_shift_next;
              r_pmod[PIN_SER] <= w_next_bit;
            end
          end
        end
        ST_LATCH: begin
          if (w_tick) begin
            r_state <= ST_IDLE;
            r_pmod  <= 3'b000;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_pmod  <= 3'b000;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready = r_ready;
  assign busy     = ~r_ready;
  assign pmod_out = r_pmod;

endmodule

// File: tb/tb_pmod_shift_tx.sv
// Directed bench for pmod_shift_tx: an MSB-first and an LSB-first instance (DATA_W=8, CLK_DIV=4).
module tb_pmod_shift_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       sel = 1'b0;

  logic       w_valid_a, w_valid_b;
  logic       ready_a, busy_a, ready_b, busy_b;
  logic [2:0] pmod_a, pmod_b;
  logic [2:0] w_pmod;
  logic       w_ready, w_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign w_valid_a = tx_valid & ~sel;
  assign w_valid_b = tx_valid & sel;
  assign w_pmod    = sel ? pmod_b  : pmod_a;
  assign w_ready   = sel ? ready_b : ready_a;
  assign w_busy    = sel ? busy_b  : busy_a;

  pmod_shift_tx #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1)) u_msb (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (w_valid_a),
    .tx_ready (ready_a),
    .busy     (busy_a),
    .pmod_out (pmod_a)
  );

  pmod_shift_tx #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(0)) u_lsb (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (w_valid_b),
    .tx_ready (ready_b),
    .busy     (busy_b),
    .pmod_out (pmod_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Presents one frame for a single accept edge; with hold set, tx_valid stays high with hold_data.
  task automatic send(input logic [7:0] d, input bit lsb_dut, input bit hold, input logic [7:0] hold_data);
    @(negedge clk);
    sel      = lsb_dut;
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold) tx_data = hold_data;
    else      tx_valid = 1'b0;
  endtask

  // Called at the negedge after an accept edge; follows the frame until tx_ready returns.
  task automatic watch(input string tag, input logic [7:0] exp_bits);
    int         cyc = 0;
    int         rises = 0;
    int         rclk_hi = 0;
    int         pulses = 0;
    logic       prev_sr = 1'b0;
    logic       prev_rc = 1'b0;
    logic [7:0] rx = 8'h00;
    check({tag, "_busy_start"}, {31'd0, w_busy}, 32'd1);
    while (!w_ready && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (w_pmod[1] && !prev_sr) begin
        rises++;
        rx = {rx[6:0], w_pmod[0]};
      end
      if (w_pmod[2]) rclk_hi++;
      if (w_pmod[2] && !prev_rc) pulses++;
      prev_sr = w_pmod[1];
      prev_rc = w_pmod[2];
    end
    check({tag, "_latency"}, cyc, 32'd68);
    check({tag, "_rises"}, rises, 32'd8);
    check({tag, "_ser_bits"}, {24'd0, rx}, {24'd0, exp_bits});
    check({tag, "_rclk_width"}, rclk_hi, 32'd4);
    check({tag, "_rclk_pulses"}, pulses, 32'd1);
    check({tag, "_idle_pins"}, {29'd0, w_pmod}, 32'd0);
    check({tag, "_busy_end"}, {31'd0, w_busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rc_seen;
    bit act;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("idle_pmod", {29'd0, pmod_a}, 32'd0);
      check("idle_ready", {31'd0, ready_a}, 32'd1);
      check("idle_busy", {31'd0, busy_a}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end

    send(8'hA5, 1'b0, 1'b0, 8'h00);
    watch("a5", 8'hA5);

    // LSB-first: bit 0 goes out first, so the collected order is bit-reversed.
    send(8'h01, 1'b1, 1'b0, 8'h00);
    watch("lsb01", 8'h80);

    send(8'h3C, 1'b0, 1'b1, 8'hFF);
    watch("hold3c", 8'h3C);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    check("ff_accepted", {31'd0, w_ready}, 32'd0);
    watch("ff", 8'hFF);

    send(8'hA5, 1'b0, 1'b0, 8'h00);
    rc_seen = 1'b0;
    for (int i = 0; i < 29; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (w_pmod[2]) rc_seen = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_pmod", {29'd0, w_pmod}, 32'd0);
    check("rst_ready", {31'd0, w_ready}, 32'd1);
    check("rst_busy", {31'd0, w_busy}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (w_pmod[2]) rc_seen = 1'b1;
    end
    check("rst_no_rclk", {31'd0, rc_seen}, 32'd0);

`ifdef PMOD_SHIFT_TX_SKIP_DUP_EN
    send(8'h5A, 1'b0, 1'b0, 8'h00);
    watch("dup_first", 8'h5A);
    send(8'h5A, 1'b0, 1'b0, 8'h00);
    act = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (w_pmod != 3'b000 || !w_ready) act = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    check("dup_skipped", {31'd0, act}, 32'd0);
    send(8'h5B, 1'b0, 1'b0, 8'h00);
    watch("dup_5b", 8'h5B);
`else
    act = 1'b0;
    send(8'h5A, 1'b0, 1'b0, 8'h00);
    watch("rep_first", 8'h5A);
    send(8'h5A, 1'b0, 1'b0, 8'h00);
    if (!w_busy) act = 1'b1;
    check("rep_not_skipped", {31'd0, act}, 32'd0);
    watch("rep_second", 8'h5A);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
